// File: rtl/sprite_frame_scheduler_if.sv
// Renderer stream and VGA plot port shared by the scheduler and its neighbours.
// The scheduler takes the master side; state_dbg exposes its FSM state.
interface sprite_frame_scheduler_if;
   logic [7:0] render_x;
   logic [6:0] render_y;
   logic [2:0] render_colour;
   logic       render_done;
   logic       go_render;
   logic       go_shift;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic [2:0] state_dbg;

   modport master (
      input  render_x, render_y, render_colour, render_done,
      output go_render, go_shift, vga_x, vga_y, vga_colour, vga_plot, state_dbg
   );

   modport slave (
      output render_x, render_y, render_colour, render_done,
      input  go_render, go_shift, vga_x, vga_y, vga_colour, vga_plot, state_dbg
   );
endinterface

// File: rtl/sprite_frame_scheduler.sv
// Frame sequencer for one sprite: draw via the renderer, hold N frames,
// erase the bounding box, request a shift, settle, repeat while run is high.
module sprite_frame_scheduler #(
   parameter int         SPR_W           = 13,
   parameter int         SPR_H           = 15,
   parameter int         LEAD            = 3,
   parameter int         TICKS_PER_FRAME = 833334,
   parameter int         FRAMES_PER_STEP = 4,
   parameter logic [2:0] BG_COLOUR       = 3'b000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic busy,
   sprite_frame_scheduler_if.master bus
);

   typedef enum logic [2:0] {IDLE, GO, DRAW, HOLD, ERASE, SHIFT, SETTLE} state_t;

   localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int DW = (LEAD > 0) ? $clog2(LEAD + 1) : 1;
   localparam int HW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP + 1) : 1;
   localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FRAME - 1);
   localparam logic [DW-1:0] DC_FULL   = DW'(LEAD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(FRAMES_PER_STEP - 1);
   localparam logic [XW-1:0] EX_LAST   = XW'(SPR_W - 1);
   localparam logic [YW-1:0] EY_LAST   = YW'(SPR_H - 1);

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [DW-1:0] dc;
   logic [HW-1:0] hold_cnt;
   logic [XW-1:0] ex;
   logic [YW-1:0] ey;
   logic [XW-1:0] next_ex;
   logic [YW-1:0] next_ey;
   logic [7:0]    org_x;
   logic [6:0]    org_y;
   logic          plotted;
   logic          settle_cnt;

   assign tick          = (tick_cnt == TICK_LAST);
   assign next_ex       = (ex == EX_LAST) ? '0 : ex + 1'b1;
   assign next_ey       = (ex == EX_LAST) ? ey + 1'b1 : ey;
   assign bus.state_dbg = state;

   // Free-running frame timebase, independent of the FSM.
   always_ff @(posedge clk) begin
      if (reset || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         dc             <= '0;
         hold_cnt       <= '0;
         ex             <= '0;
         ey             <= '0;
         org_x          <= '0;
         org_y          <= '0;
         plotted        <= 1'b0;
         settle_cnt     <= 1'b0;
         busy           <= 1'b0;
         bus.go_render  <= 1'b0;
         bus.go_shift   <= 1'b0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
      end else begin
         bus.go_render <= 1'b0;
         bus.go_shift  <= 1'b0;
         case (state)
            IDLE: begin
               bus.vga_plot <= 1'b0;
               if (run) begin
                  state         <= GO;
                  bus.go_render <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            GO: begin
               state   <= DRAW;
               dc      <= '0;
               plotted <= 1'b0;
            end
            DRAW: begin
               if (dc != DC_FULL) dc <= dc + 1'b1;
               bus.vga_x      <= bus.render_x;
               bus.vga_y      <= bus.render_y;
               bus.vga_colour <= bus.render_colour;
               if (dc == DC_FULL && bus.render_done) begin
                  state        <= HOLD;
                  hold_cnt     <= '0;
                  bus.vga_plot <= 1'b0;
               end else begin
                  bus.vga_plot <= (dc == DC_FULL);
                  // The first plotted pixel anchors the erase box.
                  if (dc == DC_FULL && !plotted) begin
                     org_x   <= bus.render_x;
                     org_y   <= bus.render_y;
                     plotted <= 1'b1;
                  end
               end
            end
            HOLD: begin
               bus.vga_plot <= 1'b0;
               if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state          <= ERASE;
                     ex             <= '0;
                     ey             <= '0;
                     bus.vga_x      <= org_x;
                     bus.vga_y      <= org_y;
                     bus.vga_colour <= BG_COLOUR;
                     bus.vga_plot   <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            ERASE: begin
               // Outputs always show pixel (ex, ey); each edge loads the next one.
               if (ex == EX_LAST && ey == EY_LAST) begin
                  state        <= SHIFT;
                  bus.vga_plot <= 1'b0;
                  bus.go_shift <= 1'b1;
               end else begin
                  ex         <= next_ex;
                  ey         <= next_ey;
                  bus.vga_x  <= org_x + 8'(next_ex);
                  bus.vga_y  <= org_y + 7'(next_ey);
               end
            end
            SHIFT: begin
               state      <= SETTLE;
               settle_cnt <= 1'b0;
            end
            SETTLE: begin
               if (!settle_cnt) begin
                  settle_cnt <= 1'b1;
               end else if (run) begin
                  state         <= GO;
                  bus.go_render <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
